// File: rtl/multi_reaction_timer_pkg.sv
// Shared types and helpers for the multi-player reaction timer.
// Holds the round state encoding and the winner-index width rule.
package multi_reaction_timer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    GO     = 2'd2,
    REPORT = 2'd3
  } state_t;

  // A single-player build still needs a 1-bit Winner field.
  function automatic int win_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multi_reaction_timer_ms_tick_gen.sv
// Prescaler that emits a one-cycle tick every TICK_DIV clocks.
// A synchronous clear restarts the count so the next tick is TICK_DIV cycles away.
module ms_tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic Clk,
  input  logic Rst,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] r_cnt;

  assign o_tick = (r_cnt == CW'(TICK_DIV - 1));

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_cnt <= '0;
    end else if (i_clr || o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/multi_reaction_timer.sv
// N-player reaction timer: random pre-delay, GO phase timing, cheat/slow flags, winner pick.
// Define BEST_TIME_EN to add the BestTime output tracking the best winning time across rounds.
module multi_reaction_timer
  import multi_reaction_timer_pkg::*;
#(
  parameter int PLAYERS  = 2,
  parameter int TIME_W   = 10,
  parameter int RAND_W   = 13,
  parameter int TICK_DIV = 50000,
  parameter int TIMEOUT  = 1000,
  parameter int LED_W    = 8
) (
  input  logic                          Clk,
  input  logic                          Rst,
  input  logic                          Start,
  input  logic [PLAYERS-1:0]            Press,
  input  logic [RAND_W-1:0]             RandomValue,
  output logic [LED_W-1:0]              LED,
  output logic [PLAYERS*TIME_W-1:0]     ReactionTime,
  output logic [PLAYERS-1:0]            Cheat,
  output logic [PLAYERS-1:0]            Slow,
  output logic [win_width(PLAYERS)-1:0] Winner,
  output logic                          WinnerValid,
  output logic                          Wait,
  output logic                          LCDUpdate,
  input  logic                          LCDAck
`ifdef BEST_TIME_EN
  ,
  output logic [TIME_W-1:0]             BestTime
`endif
);

  localparam int WIN_W = win_width(PLAYERS);

  state_t                      r_state, w_state_nxt;
  logic                        r_start_q;
  logic                        w_start_edge;
  logic [RAND_W-1:0]           r_delay, w_delay_nxt;
  logic [TIME_W-1:0]           r_react, w_react_nxt;
  logic [PLAYERS*TIME_W-1:0]   r_time, w_time_nxt;
  logic [PLAYERS-1:0]          r_cheat, w_cheat_nxt;
  logic [PLAYERS-1:0]          r_slow, w_slow_nxt;
  logic [PLAYERS-1:0]          r_latched, w_latched_nxt;
  logic [WIN_W-1:0]            r_winner, w_win_idx;
  logic                        r_wvalid, w_win_found;
  logic [TIME_W-1:0]           w_win_time;
  logic                        w_tick, w_tick_clr, w_report_entry;

  assign w_start_edge   = Start & ~r_start_q;
  assign w_report_entry = (w_state_nxt == REPORT) && (r_state != REPORT);
  assign w_tick_clr     = (w_state_nxt != r_state) && ((w_state_nxt == WAIT) || (w_state_nxt == GO));

  ms_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .Clk    (Clk),
    .Rst    (Rst),
    .i_clr  (w_tick_clr),
    .o_tick (w_tick)
  );

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state   <= IDLE;
      r_start_q <= 1'b0;
      r_delay   <= '0;
      r_react   <= '0;
      r_time    <= '0;
      r_cheat   <= '0;
      r_slow    <= '0;
      r_latched <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_start_q <= Start;
      r_delay   <= w_delay_nxt;
      r_react   <= w_react_nxt;
      r_time    <= w_time_nxt;
      r_cheat   <= w_cheat_nxt;
      r_slow    <= w_slow_nxt;
      r_latched <= w_latched_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_delay_nxt   = r_delay;
    w_react_nxt   = r_react;
    w_time_nxt    = r_time;
    w_cheat_nxt   = r_cheat;
    w_slow_nxt    = r_slow;
    w_latched_nxt = r_latched;
    case (r_state)
      IDLE: begin
        if (w_start_edge) begin
          w_time_nxt    = '0;
          w_cheat_nxt   = '0;
          w_slow_nxt    = '0;
          w_latched_nxt = '0;
          w_delay_nxt   = (RandomValue == '0) ? RAND_W'(1) : RandomValue;
          w_state_nxt   = WAIT;
        end
      end
      WAIT: begin
        w_cheat_nxt = r_cheat | Press;
        if (&w_cheat_nxt) begin
          w_state_nxt = REPORT;
        end else if (w_tick) begin
          w_delay_nxt = r_delay - 1'b1;
          if (r_delay == RAND_W'(1)) begin
            w_react_nxt = '0;
            w_state_nxt = GO;
          end
        end
      end
      GO: begin
        // The timeout tick wins over any press landing on the same cycle.
        if (w_tick && (r_react == TIME_W'(TIMEOUT - 1))) begin
          for (int p = 0; p < PLAYERS; p++) begin
            if (!r_cheat[p] && !r_latched[p]) begin
              w_slow_nxt[p]                   = 1'b1;
              w_time_nxt[p*TIME_W +: TIME_W] = TIME_W'(TIMEOUT);
            end
          end
          w_state_nxt = REPORT;
        end else begin
          for (int p = 0; p < PLAYERS; p++) begin
            if (Press[p] && !r_cheat[p] && !r_latched[p]) begin
              w_latched_nxt[p]                = 1'b1;
              w_time_nxt[p*TIME_W +: TIME_W] = r_react;
            end
          end
          if (&(w_latched_nxt | r_cheat)) w_state_nxt = REPORT;
          if (w_tick) w_react_nxt = r_react + 1'b1;
        end
      end
      REPORT: begin
        if (LCDAck) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Strict less-than keeps the lowest index on ties.
  always_comb begin
    w_win_found = 1'b0;
    w_win_idx   = '0;
    w_win_time  = '0;
    for (int p = 0; p < PLAYERS; p++) begin
      if (!w_cheat_nxt[p] && !w_slow_nxt[p] &&
          (!w_win_found || (w_time_nxt[p*TIME_W +: TIME_W] < w_win_time))) begin
        w_win_found = 1'b1;
        w_win_idx   = WIN_W'(p);
        w_win_time  = w_time_nxt[p*TIME_W +: TIME_W];
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_winner <= '0;
      r_wvalid <= 1'b0;
    end else if ((r_state == IDLE) && w_start_edge) begin
      r_winner <= '0;
      r_wvalid <= 1'b0;
    end else if (w_report_entry) begin
      r_winner <= w_win_idx;
      r_wvalid <= w_win_found;
    end
  end

`ifdef BEST_TIME_EN
  logic [TIME_W-1:0] r_best;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_best <= '1;
    end else if (w_report_entry && w_win_found && (w_win_time < r_best)) begin
      r_best <= w_win_time;
    end
  end

  assign BestTime = r_best;
`endif

  assign LED          = (r_state == GO) ? {LED_W{1'b1}} : '0;
  assign Wait         = (r_state == WAIT);
  assign LCDUpdate    = (r_state == REPORT);
  assign ReactionTime = r_time;
  assign Cheat        = r_cheat;
  assign Slow         = r_slow;
  assign Winner       = r_winner;
  assign WinnerValid  = r_wvalid;

endmodule

// File: tb/tb_multi_reaction_timer.sv
// Directed self-checking bench for multi_reaction_timer (PLAYERS=2, TICK_DIV=2, TIMEOUT=20).
// Define BEST_TIME_EN to also exercise BestTime tracking.
module tb_multi_reaction_timer;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        Start = 1'b0;
  logic [1:0]  Press = '0;
  logic [12:0] RandomValue = '0;
  logic        LCDAck = 1'b0;
  logic [7:0]  LED;
  logic [19:0] ReactionTime;
  logic [1:0]  Cheat, Slow;
  logic [0:0]  Winner;
  logic        WinnerValid, Wait, LCDUpdate;
`ifdef BEST_TIME_EN
  logic [9:0]  BestTime;
`endif

  logic [9:0] t0, t1;
  assign t0 = ReactionTime[9:0];
  assign t1 = ReactionTime[19:10];

  int n_tests = 0;
  int n_fail  = 0;
  logic led_seen = 1'b0;

  multi_reaction_timer #(
    .PLAYERS(2), .TIME_W(10), .RAND_W(13), .TICK_DIV(2), .TIMEOUT(20), .LED_W(8)
  ) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Press(Press), .RandomValue(RandomValue),
    .LED(LED), .ReactionTime(ReactionTime), .Cheat(Cheat), .Slow(Slow),
    .Winner(Winner), .WinnerValid(WinnerValid), .Wait(Wait),
    .LCDUpdate(LCDUpdate), .LCDAck(LCDAck)
`ifdef BEST_TIME_EN
    , .BestTime(BestTime)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 Clk = ~Clk;

  always @(negedge Clk) if (LED !== 8'h00) led_seen = 1'b1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Rst = 1'b0; Start = 1'b0; Press = '0; LCDAck = 1'b0; RandomValue = '0;
    repeat (3) step();
    Rst = 1'b1;
    step();
  endtask

  // Returns in WAIT cycle 0.
  task automatic start_round(input logic [12:0] rv);
    Start = 1'b1; RandomValue = rv;
    step();
    Start = 1'b0;
  endtask

  // Counts remaining WAIT cycles; returns in GO cycle 0.
  task automatic wait_go(output int n);
    n = 0;
    while (Wait === 1'b1 && n < 200) begin
      n++;
      step();
    end
  endtask

  // Press player p at GO cycle k_p (-1: never); returns once LCDUpdate is seen.
  task automatic run_go(input int k0, input int k1, output int n);
    n = 0;
    while (LCDUpdate !== 1'b1 && n < 100) begin
      Press[0] = (n == k0);
      Press[1] = (n == k1);
      step();
      n++;
    end
    Press = '0;
  endtask

  task automatic ack();
    LCDAck = 1'b1;
    step();
    LCDAck = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    Rst = 1'b0;
    #1;
    n_tests++; if (LED !== 8'h00) begin n_fail++; $display("FAIL reset_led: got %0h exp 0", LED); end
    n_tests++; if (ReactionTime !== 20'h0) begin n_fail++; $display("FAIL reset_time: got %0h exp 0", ReactionTime); end
    n_tests++; if ({Cheat, Slow} !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got %b exp 0000", {Cheat, Slow}); end
    n_tests++; if ({Winner, WinnerValid, Wait, LCDUpdate} !== 4'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b exp 0000", {Winner, WinnerValid, Wait, LCDUpdate}); end
`ifdef BEST_TIME_EN
    n_tests++; if (BestTime !== 10'h3ff) begin n_fail++; $display("FAIL reset_best: got %0h exp 3ff", BestTime); end
`endif
    do_reset();
  endtask

  task automatic test_basic();
    int n;
    start_round(13'd5);
    n_tests++; if (Wait !== 1'b1) begin n_fail++; $display("FAIL basic_wait_rise: got %b exp 1", Wait); end
    wait_go(n);
    n_tests++; if (n != 10) begin n_fail++; $display("FAIL basic_wait_len: got %0d exp 10", n); end
    n_tests++; if (LED !== 8'hff) begin n_fail++; $display("FAIL basic_led: got %0h exp ff", LED); end
    run_go(7, 13, n);
    n_tests++; if (n != 14) begin n_fail++; $display("FAIL basic_go_len: got %0d exp 14", n); end
    n_tests++; if (t0 !== 10'd3 || t1 !== 10'd6) begin n_fail++; $display("FAIL basic_times: got %0d/%0d exp 3/6", t0, t1); end
    n_tests++; if ({Winner, WinnerValid} !== 2'b01) begin n_fail++; $display("FAIL basic_winner: got %b exp 01", {Winner, WinnerValid}); end
    n_tests++; if ({Cheat, Slow, LED} !== 12'h0) begin n_fail++; $display("FAIL basic_flags: got %h exp 0", {Cheat, Slow, LED}); end
    Press = 2'b11;
    repeat (3) step();
    Press = '0;
    n_tests++; if (LCDUpdate !== 1'b1) begin n_fail++; $display("FAIL basic_lcd_hold: got %b exp 1", LCDUpdate); end
    n_tests++; if (t0 !== 10'd3 || t1 !== 10'd6) begin n_fail++; $display("FAIL basic_report_press: got %0d/%0d exp 3/6", t0, t1); end
    ack();
    n_tests++; if ({LCDUpdate, Wait, LED} !== 10'h0) begin n_fail++; $display("FAIL basic_idle: got %h exp 0", {LCDUpdate, Wait, LED}); end
    n_tests++; if (t0 !== 10'd3 || WinnerValid !== 1'b1) begin n_fail++; $display("FAIL basic_hold: got %0d/%b exp 3/1", t0, WinnerValid); end
    step();
  endtask

  task automatic test_cheat();
    int n;
    start_round(13'd5);
    step(); step();
    Press = 2'b10; Start = 1'b1;
    step();
    Press = '0; Start = 1'b0;
    n_tests++; if (Cheat !== 2'b10 || Wait !== 1'b1) begin n_fail++; $display("FAIL cheat_wait: got %b/%b exp 10/1", Cheat, Wait); end
    wait_go(n);
    n_tests++; if (n != 7) begin n_fail++; $display("FAIL cheat_wait_len: got %0d exp 7", n); end
    run_go(9, -1, n);
    n_tests++; if (n != 10) begin n_fail++; $display("FAIL cheat_go_len: got %0d exp 10", n); end
    n_tests++; if (Cheat !== 2'b10 || Slow !== 2'b00) begin n_fail++; $display("FAIL cheat_flags: got %b/%b exp 10/00", Cheat, Slow); end
    n_tests++; if (t0 !== 10'd4 || t1 !== 10'd0) begin n_fail++; $display("FAIL cheat_times: got %0d/%0d exp 4/0", t0, t1); end
    n_tests++; if ({Winner, WinnerValid} !== 2'b01) begin n_fail++; $display("FAIL cheat_winner: got %b exp 01", {Winner, WinnerValid}); end
    ack();
    step();
  endtask

  task automatic test_all_cheat();
    led_seen = 1'b0;
    start_round(13'd5);
    Press = 2'b01;
    step();
    Press = '0;
    step();
    Press = 2'b10;
    step();
    Press = '0;
    n_tests++; if (LCDUpdate !== 1'b1) begin n_fail++; $display("FAIL allcheat_report: got %b exp 1", LCDUpdate); end
    n_tests++; if (Cheat !== 2'b11 || WinnerValid !== 1'b0) begin n_fail++; $display("FAIL allcheat_flags: got %b/%b exp 11/0", Cheat, WinnerValid); end
    n_tests++; if (ReactionTime !== 20'h0 || Slow !== 2'b00) begin n_fail++; $display("FAIL allcheat_times: got %h/%b exp 0/00", ReactionTime, Slow); end
    ack();
    n_tests++; if (led_seen !== 1'b0) begin n_fail++; $display("FAIL allcheat_led: got %b exp 0", led_seen); end
    step();
  endtask

  task automatic test_boundary();
    int n;
    start_round(13'd0);
    n_tests++; if (Wait !== 1'b1) begin n_fail++; $display("FAIL bnd_wait0: got %b exp 1", Wait); end
    step();
    n_tests++; if (Wait !== 1'b1) begin n_fail++; $display("FAIL bnd_wait1: got %b exp 1", Wait); end
    Press = 2'b01;
    step();
    Press = '0;
    n_tests++; if (LED !== 8'hff || Cheat !== 2'b01) begin n_fail++; $display("FAIL bnd_last_wait: got %h/%b exp ff/01", LED, Cheat); end
    run_go(-1, 0, n);
    n_tests++; if (n != 1 || t1 !== 10'd0 || t0 !== 10'd0) begin n_fail++; $display("FAIL bnd_first_go: got %0d/%0d/%0d exp 1/0/0", n, t0, t1); end
    n_tests++; if ({Winner, WinnerValid} !== 2'b11) begin n_fail++; $display("FAIL bnd_winner: got %b exp 11", {Winner, WinnerValid}); end
    ack();
    step();
  endtask

  task automatic test_timeout();
    int n;
    start_round(13'd3);
    wait_go(n);
    n_tests++; if (n != 6) begin n_fail++; $display("FAIL to_wait_len: got %0d exp 6", n); end
    run_go(-1, -1, n);
    n_tests++; if (n != 40) begin n_fail++; $display("FAIL to_go_len: got %0d exp 40", n); end
    n_tests++; if (Slow !== 2'b11 || t0 !== 10'd20 || t1 !== 10'd20) begin n_fail++; $display("FAIL to_slow: got %b %0d/%0d exp 11 20/20", Slow, t0, t1); end
    n_tests++; if (WinnerValid !== 1'b0 || Cheat !== 2'b00) begin n_fail++; $display("FAIL to_valid: got %b/%b exp 0/00", WinnerValid, Cheat); end
    ack();
    step();
    start_round(13'd2);
    wait_go(n);
    run_go(39, 38, n);
    n_tests++; if (n != 40 || Slow !== 2'b01) begin n_fail++; $display("FAIL to_edge_slow: got %0d/%b exp 40/01", n, Slow); end
    n_tests++; if (t0 !== 10'd20 || t1 !== 10'd19) begin n_fail++; $display("FAIL to_edge_times: got %0d/%0d exp 20/19", t0, t1); end
    n_tests++; if ({Winner, WinnerValid} !== 2'b11) begin n_fail++; $display("FAIL to_edge_winner: got %b exp 11", {Winner, WinnerValid}); end
    ack();
    step();
  endtask

  task automatic test_tie();
    int n;
    LCDAck = 1'b1;
    start_round(13'd4);
    wait_go(n);
    run_go(6, 6, n);
    n_tests++; if (n != 7 || LCDUpdate !== 1'b1) begin n_fail++; $display("FAIL tie_report: got %0d/%b exp 7/1", n, LCDUpdate); end
    n_tests++; if (t0 !== 10'd3 || t1 !== 10'd3) begin n_fail++; $display("FAIL tie_times: got %0d/%0d exp 3/3", t0, t1); end
    n_tests++; if ({Winner, WinnerValid} !== 2'b01) begin n_fail++; $display("FAIL tie_winner: got %b exp 01", {Winner, WinnerValid}); end
    step();
    LCDAck = 1'b0;
    n_tests++; if (LCDUpdate !== 1'b0 || t1 !== 10'd3) begin n_fail++; $display("FAIL tie_ack: got %b/%0d exp 0/3", LCDUpdate, t1); end
    step();
  endtask

  task automatic test_winner_p1();
    int n;
    start_round(13'd1);
    wait_go(n);
    run_go(12, 4, n);
    n_tests++; if (n != 13 || t0 !== 10'd6 || t1 !== 10'd2) begin n_fail++; $display("FAIL p1_times: got %0d %0d/%0d exp 13 6/2", n, t0, t1); end
    n_tests++; if ({Winner, WinnerValid} !== 2'b11) begin n_fail++; $display("FAIL p1_winner: got %b exp 11", {Winner, WinnerValid}); end
    ack();
    step();
  endtask

  task automatic test_reset_mid_go();
    int n;
    start_round(13'd2);
    wait_go(n);
    repeat (3) step();
    Press = 2'b01;
    step();
    Press = '0;
    n_tests++; if (t0 !== 10'd1 || LED !== 8'hff) begin n_fail++; $display("FAIL rst_pre: got %0d/%h exp 1/ff", t0, LED); end
    Rst = 1'b0;
    #1;
    n_tests++; if ({LED, ReactionTime, Cheat, Slow} !== 32'h0) begin n_fail++; $display("FAIL rst_mid_data: got %h exp 0", {LED, ReactionTime, Cheat, Slow}); end
    n_tests++; if ({Winner, WinnerValid, Wait, LCDUpdate} !== 4'b0) begin n_fail++; $display("FAIL rst_mid_ctrl: got %b exp 0000", {Winner, WinnerValid, Wait, LCDUpdate}); end
    #2;
    Rst = 1'b1;
    step(); step();
    start_round(13'd5);
    wait_go(n);
    n_tests++; if (n != 10) begin n_fail++; $display("FAIL rst_after_wait: got %0d exp 10", n); end
    run_go(7, 13, n);
    n_tests++; if (t0 !== 10'd3 || t1 !== 10'd6 || {Winner, WinnerValid} !== 2'b01) begin n_fail++; $display("FAIL rst_after_round: got %0d/%0d %b exp 3/6 01", t0, t1, {Winner, WinnerValid}); end
    ack();
    step();
  endtask

`ifdef BEST_TIME_EN
  task automatic test_best_time();
    int n;
    do_reset();
    n_tests++; if (BestTime !== 10'h3ff) begin n_fail++; $display("FAIL best_init: got %0h exp 3ff", BestTime); end
    start_round(13'd1); wait_go(n); run_go(10, 16, n); ack(); step();
    n_tests++; if (BestTime !== 10'd5) begin n_fail++; $display("FAIL best_r1: got %0d exp 5", BestTime); end
    start_round(13'd1); wait_go(n); run_go(6, 8, n); ack(); step();
    n_tests++; if (BestTime !== 10'd3) begin n_fail++; $display("FAIL best_r2: got %0d exp 3", BestTime); end
    start_round(13'd1); wait_go(n); run_go(8, 12, n); ack(); step();
    n_tests++; if (BestTime !== 10'd3) begin n_fail++; $display("FAIL best_r3: got %0d exp 3", BestTime); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_cheat();
    test_all_cheat();
    test_boundary();
    test_timeout();
    test_tie();
    test_winner_p1();
    test_reset_mid_go();
`ifdef BEST_TIME_EN
    test_best_time();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_reaction_timer.md
# multi_reaction_timer

Parametrised N-player reaction timer, successor to the single-player reaction timer. Runs a random pre-delay, lights the LEDs, and times each player's press independently in millisecond ticks. It flags cheats (pressed early) and slow players (timeout) per player and picks a winner. Results go to the LCD driver through the existing LCDUpdate/LCDAck handshake.

## Interface
Parameters:
- PLAYERS, 2: number of player buttons (1–8).
- TIME_W, 10: width of each reaction-time field.
- RAND_W, 13: width of RandomValue (pre-delay in ticks).
- TICK_DIV, 50000: Clk cycles per timing tick (1 ms at 50 MHz).
- TIMEOUT, 1000: tick count at which unpressed players are Slow; must be ≤ 2^TIME_W−1.
- LED_W, 8: LED bus width.

Ports:
- Clk  in  1  system clock, all logic on rising edge.
- Rst  in  1  asynchronous, active-low reset.
- Start  in  1  level input; its rising edge starts a round.
- Press  in  PLAYERS  per-player button, already debounced and synchronised.
- RandomValue  in  RAND_W  pre-delay, sampled on round start.
- LED  out  LED_W  all ones in GO, else zero.
- ReactionTime  out  PLAYERS*TIME_W  player p in bits [p*TIME_W +: TIME_W].
- Cheat  out  PLAYERS  per-player early press.
- Slow  out  PLAYERS  per-player timeout.
- Winner  out  $clog2(PLAYERS) (min 1)  index of the fastest valid player.
- WinnerValid  out  1  Winner is meaningful.
- Wait  out  1  high in WAIT.
- LCDUpdate  out  1  results ready, held until LCDAck.
- LCDAck  in  1  LCD driver consumed the results.

## Operation
- States: IDLE, WAIT, GO, REPORT.
- IDLE: a rising edge on Start (registered compare) clears all result outputs and loads the delay counter with RandomValue (0 is treated as 1), then goes to WAIT.
- WAIT: the delay counter decrements once per tick and the state moves to GO when it reaches 0.
  - Press[p] in WAIT sets Cheat[p]. That player is out for the round and its time stays 0.
  - If all players have cheated, the block goes directly to REPORT.
- GO: the reaction counter starts at 0 and increments once per tick.
  - The first Press[p] from a non-cheated player latches the counter into ReactionTime[p]. Later presses are ignored.
  - When every active player has latched, the block goes to REPORT.
  - If the counter reaches TIMEOUT, every unlatched active player gets Slow[p]=1 and ReactionTime[p]=TIMEOUT, then the block goes to REPORT.
- Winner is the minimum time among players with no Cheat and no Slow. Ties go to the lowest index. WinnerValid=0 if no such player exists.
- REPORT: LCDUpdate=1. When LCDAck=1, the block goes to IDLE.
- Results hold through IDLE until the next Start edge.
- Start is ignored outside IDLE. LCDAck is ignored outside REPORT.
- Press in IDLE or REPORT is ignored.

## Timing
- Reset (Rst=0, asynchronous): state IDLE; LED, ReactionTime, Cheat, Slow, Winner, WinnerValid, Wait and LCDUpdate are all 0; counters, prescaler and the Start edge register are 0.
- Reset mid-round aborts the round immediately with no report.
- Start edge: WAIT is entered on the clock after the edge is seen, and Wait rises in that same cycle.
- The prescaler clears on entry to WAIT and to GO, so the first tick comes exactly TICK_DIV cycles after entry.
- WAIT lasts RandomValue×TICK_DIV cycles.
- Reaction time: a press in the first TICK_DIV cycles of GO latches 0.
- A press on the same cycle as the tick that reaches TIMEOUT counts as Slow.
- Simultaneous presses latch the same value.
- Press on the last WAIT cycle (the tick that reaches 0) counts as Cheat.
- Winner and WinnerValid are registered and valid in the cycle REPORT is entered, together with LCDUpdate.
- LCDAck high during REPORT: LCDUpdate falls and the state is IDLE on the next cycle.

## Configuration
- BEST_TIME_EN defined:
  - Adds output BestTime (TIME_W) and register-backed tracking of the lowest valid winning time across rounds.
  - BestTime resets to all ones and updates on REPORT entry when WinnerValid is high and the new time is lower.
  - Rst clears it.
- BEST_TIME_EN undefined: no BestTime port and no tracking logic.

## Structure
- Shared package: state enum (IDLE, WAIT, GO, REPORT) and a function for the winner index width ($clog2 with a minimum of 1).
- One sub-module, ms_tick_gen:
  - Parameter TICK_DIV; inputs Clk, Rst and a synchronous clear; output a one-cycle tick pulse.
  - The FSM, per-player latches and winner compare stay in the top level.

## Test plan
(Defaults except TICK_DIV=2, TIMEOUT=20, PLAYERS=2.)
- Start edge, RandomValue=5, Press[0] 7 cycles into GO, Press[1] 13 cycles into GO → Wait for 10 cycles; ReactionTime0=3, ReactionTime1=6; Winner=0, WinnerValid=1; LCDUpdate held until LCDAck, then IDLE.
- Press[1] during WAIT, Press[0] at 9 cycles into GO → Cheat=2'b10; ReactionTime0=4; Winner=0.
- Both players press during WAIT → REPORT the cycle after the second press; WinnerValid=0; LED never set.
- No presses in GO → after 40 cycles Slow=2'b11, both times=20, WinnerValid=0.
- Both players press on the same cycle at 6 cycles into GO → both times=3; Winner=0 (tie goes to the lowest index).
- Rst pulsed low mid-GO → all outputs 0 immediately. A new Start edge after reset runs a normal round. With BEST_TIME_EN: best of rounds 5 then 3 gives BestTime=3.
